bmem_dp_seg: RTL and testbench



---
 rtl/bmem_pkg.sv | 17 +
 rtl/bmem_rd_pipe.sv | 51 +++++
 rtl/bmem_dp_seg.sv | 114 +++++++++++
 tb/tb_bmem_dp_seg.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bmem_pkg.sv
// Shared FSM encoding, port-2 collision modes and segment helper for the segmented block memory.
package bmem_pkg;

   typedef logic [0:0] state_t;

   localparam state_t ST_IDLE  = 1'b0;
   localparam state_t ST_CLEAR = 1'b1;

   localparam int RDW_OLD = 0;
   localparam int RDW_NEW = 1;

   // Lowest bit of segment k; the merge mask is built one segment slice at a time from this.
   function automatic int seg_lo(input int k, input int seg_w);
      return k * seg_w;
   endfunction

endpackage

// File: rtl/bmem_rd_pipe.sv
// Read-data pipeline for one memory port: RD_LAT register stages for data and valid.
// Data registers load only with a valid, so the output holds between reads.
module bmem_rd_pipe
   import bmem_pkg::*;
#(
   parameter int WIDTH  = 5120,
   parameter int RD_LAT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req,
   input  logic [WIDTH-1:0] rdata,
   output logic [WIDTH-1:0] dout,
   output logic             dvalid
);

   logic [WIDTH-1:0] d1;
   logic             v1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d1 <= '0;
         v1 <= 1'b0;
      end else begin
         v1 <= req;
         if (req) d1 <= rdata;
      end
   end

   if (RD_LAT == 2) begin : g_lat2
      logic [WIDTH-1:0] d2;
      logic             v2;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            d2 <= '0;
            v2 <= 1'b0;
         end else begin
            v2 <= v1;
            if (v1) d2 <= d1;
         end
      end

      assign dout   = d2;
      assign dvalid = v2;
   end else begin : g_lat1
      assign dout   = d1;
      assign dvalid = v1;
   end

endmodule

// File: rtl/bmem_dp_seg.sv
// Dual-port block memory: port 1 read/write with segment enables, port 2 read-only,
// self-clearing after reset or init; all user accesses are ignored while busy.
module bmem_dp_seg
   import bmem_pkg::*;
#(
   parameter  int DEPTH    = 480,
   parameter  int WIDTH    = 5120,
   parameter  int SEG_W    = 512,
   parameter  int RD_LAT   = 1,
   parameter  int RDW_MODE = RDW_OLD,
   localparam int NSEG     = WIDTH / SEG_W,
   localparam int AW       = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             init,
   output logic             busy,
   input  logic             we,
   input  logic [NSEG-1:0]  wseg,
   input  logic [AW-1:0]    addr1,
   input  logic             re1,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout1,
   output logic             dvalid1,
   input  logic [AW-1:0]    addr2,
   input  logic             re2,
   output logic [WIDTH-1:0] dout2,
   output logic             dvalid2
);

   if (WIDTH % SEG_W != 0) begin : g_bad_seg
      $error("bmem_dp_seg: WIDTH must be a multiple of SEG_W");
   end
   if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
      $error("bmem_dp_seg: RD_LAT must be 1 or 2");
   end
   if (DEPTH < 2) begin : g_bad_depth
      $error("bmem_dp_seg: DEPTH must be at least 2");
   end
   if (RDW_MODE != RDW_OLD && RDW_MODE != RDW_NEW) begin : g_bad_rdw
      $error("bmem_dp_seg: RDW_MODE must be RDW_OLD or RDW_NEW");
   end

   localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

   state_t           state;
   logic [AW-1:0]    clr_cnt;
   logic [WIDTH-1:0] mem [DEPTH];

   logic             in1, in2, wr, rd1, rd2, hit;
   logic [WIDTH-1:0] wmask, rdata1, rdata2, old2;

   assign busy = (state == ST_CLEAR);
   assign in1  = {1'b0, addr1} < DEPTH_C;
   assign in2  = {1'b0, addr2} < DEPTH_C;
   assign wr   = we && !busy && in1;
   assign rd1  = re1 && !busy;
   assign rd2  = re2 && !busy;

   for (genvar k = 0; k < NSEG; k++) begin : g_mask
      assign wmask[seg_lo(k, SEG_W) +: SEG_W] = {SEG_W{wseg[k]}};
   end

   // init is only looked at in IDLE, so a running clear is never restarted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_CLEAR;
         clr_cnt <= '0;
      end else if (busy) begin
         if (clr_cnt == LAST) begin
            state   <= ST_IDLE;
            clr_cnt <= '0;
         end else begin
            clr_cnt <= clr_cnt + 1'b1;
         end
      end else if (init) begin
         state <= ST_CLEAR;
      end
   end

   always_ff @(posedge clk) begin
      if (busy) begin
         mem[clr_cnt] <= '0;
      end else if (wr) begin
         mem[addr1] <= (mem[addr1] & ~wmask) | (din & wmask);
      end
   end

   // Reads sample the array before this edge's write lands, giving read-first on both ports.
   assign rdata1 = in1 ? mem[addr1] : '0;
   assign old2   = in2 ? mem[addr2] : '0;
   assign hit    = (RDW_MODE == RDW_NEW) && wr && (addr2 == addr1);
   assign rdata2 = hit ? ((old2 & ~wmask) | (din & wmask)) : old2;

   bmem_rd_pipe #(.WIDTH(WIDTH), .RD_LAT(RD_LAT)) u_pipe1 (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (rd1),
      .rdata  (rdata1),
      .dout   (dout1),
      .dvalid (dvalid1)
   );

   bmem_rd_pipe #(.WIDTH(WIDTH), .RD_LAT(RD_LAT)) u_pipe2 (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (rd2),
      .rdata  (rdata2),
      .dout   (dout2),
      .dvalid (dvalid2)
   );

endmodule

// File: tb/tb_bmem_dp_seg.sv
// Bench for bmem_dp_seg: two configurations share one stimulus stream and are checked every
// cycle against a word-level model, plus literal expectations at the interesting points.
module tb_bmem_dp_seg;

   localparam int NC = 2;
   localparam int W  = 32;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       init  = 1'b0;
   logic       we    = 1'b0;
   logic       re1   = 1'b0;
   logic       re2   = 1'b0;
   logic [3:0] wseg  = '0;
   logic [2:0] addr1 = '0;
   logic [2:0] addr2 = '0;
   logic [W-1:0] din = '0;

   logic         busy_w [NC];
   logic         dv1_w  [NC];
   logic         dv2_w  [NC];
   logic [W-1:0] do1_w  [NC];
   logic [W-1:0] do2_w  [NC];

   int n_cmp = 0;
   int n_bad = 0;
   int bcnt [NC];

   always #5 clk = ~clk;

   // cfg0: 8 words, latency 1, old data on collision; cfg1: 6 words, latency 2, forwarding
   bmem_dp_seg #(.DEPTH(8), .WIDTH(W), .SEG_W(8), .RD_LAT(1), .RDW_MODE(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .init(init), .busy(busy_w[0]), .we(we), .wseg(wseg),
      .addr1(addr1), .re1(re1), .din(din), .dout1(do1_w[0]), .dvalid1(dv1_w[0]),
      .addr2(addr2), .re2(re2), .dout2(do2_w[0]), .dvalid2(dv2_w[0]));

   bmem_dp_seg #(.DEPTH(6), .WIDTH(W), .SEG_W(8), .RD_LAT(2), .RDW_MODE(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .init(init), .busy(busy_w[1]), .we(we), .wseg(wseg),
      .addr1(addr1), .re1(re1), .din(din), .dout1(do1_w[1]), .dvalid1(dv1_w[1]),
      .addr2(addr2), .re2(re2), .dout2(do2_w[1]), .dvalid2(dv2_w[1]));

   // ---------------- behavioural model ----------------
   int depth_c [NC] = '{8, 6};
   int lat_c   [NC] = '{1, 2};
   int rdw_c   [NC] = '{0, 1};

   logic [W-1:0] mm [NC][8];
   int           clr_left [NC];
   logic         sv [NC][2];
   logic [W-1:0] sd [NC][2];
   logic         ev [NC][2];
   logic [W-1:0] ed [NC][2];

   function automatic logic [W-1:0] merge(input logic [W-1:0] o, input logic [W-1:0] n,
                                          input logic [3:0] en);
      for (int k = 0; k < 4; k++) if (en[k]) o[k*8 +: 8] = n[k*8 +: 8];
      return o;
   endfunction

   // A clear is unobservable while busy, so the model zeroes the whole array up front.
   task automatic model_reset();
      for (int c = 0; c < NC; c++) begin
         clr_left[c] = depth_c[c];
         for (int a = 0; a < 8; a++) mm[c][a] = '0;
         for (int p = 0; p < 2; p++) begin
            sv[c][p] = 1'b0; sd[c][p] = '0; ev[c][p] = 1'b0; ed[c][p] = '0;
         end
      end
   endtask

   task automatic model_step();
      logic         nv [2];
      logic [W-1:0] nd [2];
      for (int c = 0; c < NC; c++) begin
         nv[0] = 1'b0; nv[1] = 1'b0; nd[0] = '0; nd[1] = '0;
         if (clr_left[c] > 0) begin
            clr_left[c]--;
         end else begin
            nv[0] = re1;
            nv[1] = re2;
            nd[0] = (addr1 < depth_c[c]) ? mm[c][addr1] : '0;
            nd[1] = (addr2 < depth_c[c]) ? mm[c][addr2] : '0;
            if (we && addr1 < depth_c[c]) begin
               if (rdw_c[c] == 1 && addr2 == addr1) nd[1] = merge(nd[1], din, wseg);
               mm[c][addr1] = merge(mm[c][addr1], din, wseg);
            end
            if (init) begin
               clr_left[c] = depth_c[c];
               for (int a = 0; a < 8; a++) mm[c][a] = '0;
            end
         end
         for (int p = 0; p < 2; p++) begin
            if (lat_c[c] == 1) begin
               ev[c][p] = nv[p];
               if (nv[p]) ed[c][p] = nd[p];
            end else begin
               ev[c][p] = sv[c][p];
               if (sv[c][p]) ed[c][p] = sd[c][p];
               sv[c][p] = nv[p];
               sd[c][p] = nd[p];
            end
         end
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk);
         if (!rst_n) model_reset();
         else model_step();
      end
   end

   initial forever begin
      @(negedge rst_n);
      model_reset();
   end

   // ---------------- checking ----------------
   task automatic chk(input string nm, input int c, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cfg%0d at %0t: got %h expected %h", nm, c, $time, act, exp);
      end
   endtask

   initial begin
      @(posedge clk);
      forever begin
         @(negedge clk);
         for (int c = 0; c < NC; c++) begin
            chk("busy",    c, busy_w[c], clr_left[c] > 0);
            chk("dvalid1", c, dv1_w[c],  ev[c][0]);
            chk("dvalid2", c, dv2_w[c],  ev[c][1]);
            chk("dout1",   c, do1_w[c],  ed[c][0]);
            chk("dout2",   c, do2_w[c],  ed[c][1]);
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic idle();
      init = 1'b0; we = 1'b0; re1 = 1'b0; re2 = 1'b0; wseg = '0;
   endtask

   task automatic count_busy(input int n);
      bcnt[0] = 0; bcnt[1] = 0;
      repeat (n) begin
         @(negedge clk);
         for (int c = 0; c < NC; c++) bcnt[c] += int'(busy_w[c]);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic write(input logic [2:0] a, input logic [3:0] en, input logic [W-1:0] d);
      we = 1'b1; addr1 = a; wseg = en; din = d;
      cyc(1);
      idle();
   endtask

   task automatic read_all();
      for (int a = 0; a < 8; a++) begin
         re1 = 1'b1; addr1 = 3'(a);
         re2 = 1'b1; addr2 = 3'(7 - a);
         cyc(1);
      end
      idle();
      cyc(3);
   endtask

   initial begin
      cyc(3);
      for (int c = 0; c < NC; c++) begin
         chk("rst_busy", c, busy_w[c], 1);
         chk("rst_dv1",  c, dv1_w[c],  0);
         chk("rst_dv2",  c, dv2_w[c],  0);
         chk("rst_do1",  c, do1_w[c],  0);
         chk("rst_do2",  c, do2_w[c],  0);
      end

      rst_n = 1'b1;
      count_busy(12);
      chk("busy_len_rst", 0, bcnt[0], 8);
      chk("busy_len_rst", 1, bcnt[1], 6);

      read_all();

      // full-word write then port-2 read in the next cycle
      write(3'd3, 4'hF, 32'hA5A5_A5A5);
      re2 = 1'b1; addr2 = 3'd3;
      cyc(1);
      idle();
      @(negedge clk);
      chk("wr_rd2_do", 0, do2_w[0], 32'hA5A5_A5A5);
      chk("wr_rd2_dv", 0, dv2_w[0], 1);
      chk("wr_rd2_dv_early", 1, dv2_w[1], 0);
      @(negedge clk);
      chk("wr_rd2_do", 1, do2_w[1], 32'hA5A5_A5A5);
      chk("wr_rd2_dv", 1, dv2_w[1], 1);
      chk("wr_rd2_pulse", 0, dv2_w[0], 0);
      @(posedge clk); #1;

      // segment-0-only write of zero over all-ones
      write(3'd2, 4'hF, 32'hFFFF_FFFF);
      write(3'd2, 4'b0001, 32'h0);
      re1 = 1'b1; addr1 = 3'd2;
      cyc(1);
      idle();
      @(negedge clk);
      chk("seg_wr", 0, do1_w[0], 32'hFFFF_FF00);
      @(negedge clk);
      chk("seg_wr", 1, do1_w[1], 32'hFFFF_FF00);
      @(posedge clk); #1;

      // same-cycle write and reads of addr 5
      write(3'd5, 4'hF, 32'h1122_3344);
      we = 1'b1; wseg = 4'b0101; din = 32'hAABB_CCDD; addr1 = 3'd5;
      re1 = 1'b1; re2 = 1'b1; addr2 = 3'd5;
      cyc(1);
      idle();
      @(negedge clk);
      chk("rdw_p1", 0, do1_w[0], 32'h1122_3344);
      chk("rdw_old", 0, do2_w[0], 32'h1122_3344);
      @(negedge clk);
      chk("rdw_p1", 1, do1_w[1], 32'h1122_3344);
      chk("rdw_new", 1, do2_w[1], 32'h11BB_33DD);
      @(posedge clk); #1;
      read_all();

      // address 6 exists in cfg0 but is out of range in cfg1
      write(3'd6, 4'hF, 32'hDEAD_BEEF);
      re1 = 1'b1; addr1 = 3'd6; re2 = 1'b1; addr2 = 3'd7;
      cyc(1);
      idle();
      @(negedge clk);
      chk("oor_inrange", 0, do1_w[0], 32'hDEAD_BEEF);
      @(negedge clk);
      chk("oor_do", 1, do1_w[1], 32'h0);
      chk("oor_dv", 1, dv1_w[1], 1);
      @(posedge clk); #1;

      // init, repeated init mid-clear and a write while busy
      bcnt[0] = 0; bcnt[1] = 0;
      for (int i = 0; i < 14; i++) begin
         idle();
         if (i == 0) init = 1'b1;
         if (i == 3) begin
            init = 1'b1; we = 1'b1; addr1 = 3'd1; wseg = 4'hF; din = 32'h1234_5678;
         end
         @(negedge clk);
         for (int c = 0; c < NC; c++) bcnt[c] += int'(busy_w[c]);
         @(posedge clk); #1;
      end
      idle();
      chk("busy_len_init", 0, bcnt[0], 8);
      chk("busy_len_init", 1, bcnt[1], 6);
      re1 = 1'b1; addr1 = 3'd1; re2 = 1'b1; addr2 = 3'd3;
      cyc(1);
      idle();
      @(negedge clk);
      chk("clr_word1", 0, do1_w[0], 32'h0);
      chk("clr_word3", 0, do2_w[0], 32'h0);
      @(posedge clk); #1;
      read_all();

      // reset during an outstanding read
      re1 = 1'b1; addr1 = 3'd0; re2 = 1'b1; addr2 = 3'd4;
      cyc(1);
      idle();
      chk("pre_rst_dv1", 0, dv1_w[0], 1);
      rst_n = 1'b0;
      #1;
      for (int c = 0; c < NC; c++) begin
         chk("rst_drop_dv1", c, dv1_w[c], 0);
         chk("rst_drop_dv2", c, dv2_w[c], 0);
         chk("rst_busy_now", c, busy_w[c], 1);
      end
      cyc(2);
      rst_n = 1'b1;
      count_busy(12);
      chk("busy_len_rd_rst", 0, bcnt[0], 8);
      chk("busy_len_rd_rst", 1, bcnt[1], 6);

      // reset in the middle of an init clear
      write(3'd4, 4'hF, 32'h0F0F_0F0F);
      init = 1'b1;
      cyc(1);
      idle();
      cyc(3);
      rst_n = 1'b0;
      cyc(2);
      rst_n = 1'b1;
      count_busy(12);
      chk("busy_len_clr_rst", 0, bcnt[0], 8);
      chk("busy_len_clr_rst", 1, bcnt[1], 6);
      read_all();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
